// File: rtl/motor_drive_if.sv
// Command handshake between the steering controller (master) and motor_drive (slave).
interface motor_drive_if #(
  parameter int CNT_W = 10
);
  logic           cmd_vld;
  logic [CNT_W:0] lft_cmd;
  logic [CNT_W:0] rht_cmd;
  logic           cmd_rdy;

  modport master (output cmd_vld, output lft_cmd, output rht_cmd, input cmd_rdy);
  modport slave  (input cmd_vld, input lft_cmd, input rht_cmd, output cmd_rdy);
endinterface

// File: rtl/motor_drive.sv
// Dual H-bridge driver: signed commands latched at period boundaries become
// per-motor forward/reverse PWM with a dead interval on every reversal.
module motor_drive #(
  parameter int CNT_W    = 10,
  parameter int DEADTIME = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  motor_drive_if.slave cmd_if,
  output logic         fwd_lft,
  output logic         rev_lft,
  output logic         fwd_rht,
  output logic         rev_rht
);

  typedef enum logic [1:0] {COAST, FWD, REV, DEAD} mstate_e;

  typedef struct packed {
    mstate_e          st;
    logic             tgt_rev;
    logic [CNT_W-1:0] dead;
    logic [CNT_W-1:0] duty;
  } motor_t;

  localparam logic [CNT_W-1:0] DEAD_LD   = DEADTIME[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   CMD_ONE   = {{CNT_W{1'b0}}, 1'b1};
  localparam motor_t           MOTOR_RST = '{st: COAST, tgt_rev: 1'b0, dead: '0, duty: '0};

  // The most negative command has no positive twin, so it clips to full scale.
  function automatic logic [CNT_W-1:0] mag_sat(input logic [CNT_W:0] cmd);
    logic [CNT_W:0] a;
    a = cmd[CNT_W] ? (~cmd + CMD_ONE) : cmd;
    return a[CNT_W] ? '1 : a[CNT_W-1:0];
  endfunction

  function automatic motor_t motor_next(input motor_t cur, input logic apply,
                                        input logic [CNT_W:0] cmd);
    motor_t nxt;
    logic   is_zero;
    logic   is_neg;
    nxt     = cur;
    is_zero = (cmd == '0);
    is_neg  = cmd[CNT_W];
    if (cur.st == DEAD) begin
      nxt.dead = cur.dead - ONE;
      if (cur.dead == ONE) nxt.st = cur.tgt_rev ? REV : FWD;
    end
    if (apply) begin
      nxt.duty = mag_sat(cmd);
      if (is_zero) begin
        nxt.st   = COAST;
        nxt.dead = '0;
      end else begin
        nxt.tgt_rev = is_neg;
        case (cur.st)
          COAST: nxt.st = is_neg ? REV : FWD;
          FWD: begin
            if (is_neg) begin
              nxt.st   = DEAD;
              nxt.dead = DEAD_LD;
            end else begin
              nxt.st = FWD;
            end
          end
          REV: begin
            if (!is_neg) begin
              nxt.st   = DEAD;
              nxt.dead = DEAD_LD;
            end else begin
              nxt.st = REV;
            end
          end
          DEAD: begin
            if (is_neg != cur.tgt_rev) begin
              nxt.st   = DEAD;
              nxt.dead = DEAD_LD;
            end
          end
          default: nxt.st = COAST;
        endcase
      end
    end
    return nxt;
  endfunction

  logic [CNT_W-1:0] cntr_q, cntr_d;
  logic             pend_full_q, pend_full_d;
  logic [CNT_W:0]   pend_lft_q, pend_lft_d;
  logic [CNT_W:0]   pend_rht_q, pend_rht_d;
  motor_t           lft_q, lft_d;
  motor_t           rht_q, rht_d;
  logic             fwd_lft_q, fwd_lft_d;
  logic             rev_lft_q, rev_lft_d;
  logic             fwd_rht_q, fwd_rht_d;
  logic             rev_rht_q, rev_rht_d;
  logic             boundary;
  logic             capture;
  logic             apply;

  // Capture and apply are exclusive: capture needs an empty buffer, apply a full one.
  always_comb begin
    boundary    = (cntr_q == '1);
    capture     = cmd_if.cmd_vld & ~pend_full_q;
    apply       = boundary & pend_full_q;
    cntr_d      = cntr_q + ONE;
    pend_full_d = pend_full_q;
    pend_lft_d  = pend_lft_q;
    pend_rht_d  = pend_rht_q;
    if (apply) pend_full_d = 1'b0;
    if (capture) begin
      pend_full_d = 1'b1;
      pend_lft_d  = cmd_if.lft_cmd;
      pend_rht_d  = cmd_if.rht_cmd;
    end
    lft_d     = motor_next(lft_q, apply, pend_lft_q);
    rht_d     = motor_next(rht_q, apply, pend_rht_q);
    fwd_lft_d = (lft_q.st == FWD) && (cntr_q < lft_q.duty);
    rev_lft_d = (lft_q.st == REV) && (cntr_q < lft_q.duty);
    fwd_rht_d = (rht_q.st == FWD) && (cntr_q < rht_q.duty);
    rev_rht_d = (rht_q.st == REV) && (cntr_q < rht_q.duty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntr_q      <= '1;
      pend_full_q <= 1'b0;
      pend_lft_q  <= '0;
      pend_rht_q  <= '0;
      lft_q       <= MOTOR_RST;
      rht_q       <= MOTOR_RST;
      fwd_lft_q   <= 1'b0;
      rev_lft_q   <= 1'b0;
      fwd_rht_q   <= 1'b0;
      rev_rht_q   <= 1'b0;
    end else begin
      cntr_q      <= cntr_d;
      pend_full_q <= pend_full_d;
      pend_lft_q  <= pend_lft_d;
      pend_rht_q  <= pend_rht_d;
      lft_q       <= lft_d;
      rht_q       <= rht_d;
      fwd_lft_q   <= fwd_lft_d;
      rev_lft_q   <= rev_lft_d;
      fwd_rht_q   <= fwd_rht_d;
      rev_rht_q   <= rev_rht_d;
    end
  end

  assign cmd_if.cmd_rdy = ~pend_full_q;
  assign fwd_lft        = fwd_lft_q;
  assign rev_lft        = rev_lft_q;
  assign fwd_rht        = fwd_rht_q;
  assign rev_rht        = rev_rht_q;

endmodule

// File: tb/tb_motor_drive.sv
// Scoreboard bench for motor_drive: a period-level model predicts each PWM window's
// high count and first-high offset; an independent monitor measures and compares.
module tb_motor_drive;
  localparam int CNT_W  = 10;
  localparam int PERIOD = 1 << CNT_W;
  localparam int DEADT  = 64;
  localparam int MAXD   = PERIOD - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic fwd_lft, rev_lft, fwd_rht, rev_rht;

  motor_drive_if #(.CNT_W(CNT_W)) bus ();

  motor_drive #(.CNT_W(CNT_W), .DEADTIME(DEADT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd_if  (bus),
    .fwd_lft (fwd_lft),
    .rev_lft (rev_lft),
    .fwd_rht (fwd_rht),
    .rev_rht (rev_rht)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt[4];
    int first[4];
  } expect_t;

  expect_t sb[$];
  string   ch_name[4] = '{"fwd_lft", "rev_lft", "fwd_rht", "rev_rht"};

  int vectors     = 0;
  int miscompares = 0;
  int k           = 0;
  bit exp_rdy     = 1'b1;

  // Model state: one pending pair, per-motor direction (-1/0/+1), duty, reversal flag.
  bit pend;
  int pend_l, pend_r;
  int dir[2];
  int duty[2];
  bit revr[2];

  int acc_cnt[4];
  int acc_first[4];
  int acc_ovl[2];

  // Cycle index since reset release; cycle 0 is the first boundary.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) k <= 0;
    else        k <= k + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clearAcc();
    for (int i = 0; i < 4; i++) begin
      acc_cnt[i]   = 0;
      acc_first[i] = -1;
    end
    acc_ovl[0] = 0;
    acc_ovl[1] = 0;
  endtask

  task automatic modelReset();
    pend    = 1'b0;
    pend_l  = 0;
    pend_r  = 0;
    exp_rdy = 1'b1;
    for (int m = 0; m < 2; m++) begin
      dir[m]  = 0;
      duty[m] = 0;
      revr[m] = 1'b0;
    end
  endtask

  task automatic modelApply(input int m, input int v);
    int mag;
    int nd;
    mag = (v < 0) ? -v : v;
    if (mag > MAXD) mag = MAXD;
    nd = (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    revr[m] = (dir[m] != 0) && (nd != 0) && (nd != dir[m]);
    dir[m]  = nd;
    duty[m] = mag;
  endtask

  // A reversal blanks the first DEADT clocks of the period; otherwise duty clocks high from offset 0.
  task automatic pushExpect();
    expect_t e;
    for (int m = 0; m < 2; m++) begin
      int eff;
      int first;
      eff   = revr[m] ? ((duty[m] > DEADT) ? duty[m] - DEADT : 0) : duty[m];
      first = (eff > 0) ? (revr[m] ? DEADT : 0) : -1;
      e.cnt[2*m]     = (dir[m] > 0) ? eff : 0;
      e.first[2*m]   = (dir[m] > 0) ? first : -1;
      e.cnt[2*m+1]   = (dir[m] < 0) ? eff : 0;
      e.first[2*m+1] = (dir[m] < 0) ? first : -1;
      revr[m] = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic tick(output bit cap);
    bit bnd;
    bit app;
    bnd = ((k % PERIOD) == 0);
    app = bnd && pend;
    cap = bus.cmd_vld && !pend;
    if (app) begin
      modelApply(0, pend_l);
      modelApply(1, pend_r);
      pend = 1'b0;
    end
    if (cap) begin
      pend   = 1'b1;
      pend_l = int'($signed(bus.lft_cmd));
      pend_r = int'($signed(bus.rht_cmd));
    end
    if (bnd) pushExpect();
    @(posedge clk);
    exp_rdy = !pend;
    #1;
  endtask

  task automatic idle(input int n);
    bit c;
    repeat (n) tick(c);
  endtask

  task automatic waitPhase(input int ph);
    bit c;
    int guard = 0;
    while (pend || ((k % PERIOD) != ph)) begin
      tick(c);
      guard++;
      if (guard > 3 * PERIOD) begin
        $display("[TB] FAIL waitPhase timeout at phase %0d", ph);
        $fatal(1, "[TB] stuck waiting for phase");
      end
    end
  endtask

  task automatic applyStimulus(input int l, input int r);
    bit c;
    int guard = 0;
    bus.lft_cmd = l[CNT_W:0];
    bus.rht_cmd = r[CNT_W:0];
    bus.cmd_vld = 1'b1;
    c = 1'b0;
    while (!c) begin
      tick(c);
      guard++;
      if (guard > 3 * PERIOD) begin
        $display("[TB] FAIL capture timeout for %0d/%0d", l, r);
        $fatal(1, "[TB] command never captured");
      end
    end
    bus.cmd_vld = 1'b0;
  endtask

  task automatic doReset(input int hold);
    rst_n       = 1'b0;
    bus.cmd_vld = 1'b0;
    sb.delete();
    modelReset();
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic compareWindow(input int p);
    expect_t e;
    checkOutput($sformatf("p%0d scoreboard entry present", p), int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("p%0d %s high count", p, ch_name[i]), acc_cnt[i], e.cnt[i]);
        checkOutput($sformatf("p%0d %s first-high offset", p, ch_name[i]), acc_first[i], e.first[i]);
      end
      checkOutput($sformatf("p%0d left fwd&rev overlap", p), acc_ovl[0], 0);
      checkOutput($sformatf("p%0d right fwd&rev overlap", p), acc_ovl[1], 0);
    end
    clearAcc();
  endtask

  // Window p holds the outputs driven by counter values 0..PERIOD-1 of period p.
  initial begin : monitor
    logic [3:0] o;
    int         idx;
    clearAcc();
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        o = {rev_rht, fwd_rht, rev_lft, fwd_lft};
        checkOutput("pwm during reset", int'(o), 0);
        checkOutput("cmd_rdy during reset", int'(bus.cmd_rdy), 1);
        clearAcc();
      end else begin
        checkOutput("cmd_rdy", int'(bus.cmd_rdy), int'(exp_rdy));
        if (k >= 2) begin
          o   = {rev_rht, fwd_rht, rev_lft, fwd_lft};
          idx = (k - 2) % PERIOD;
          for (int i = 0; i < 4; i++) begin
            if (o[i]) begin
              acc_cnt[i]++;
              if (acc_first[i] < 0) acc_first[i] = idx;
            end
          end
          if (o[0] && o[1]) acc_ovl[0]++;
          if (o[2] && o[3]) acc_ovl[1]++;
          if (idx == PERIOD - 1) compareWindow((k - 2) / PERIOD);
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin : stim
    bit c;
    int l;
    int r;
    bus.cmd_vld = 1'b0;
    bus.lft_cmd = '0;
    bus.rht_cmd = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    $display("[TB] reset released, idling");
    idle(3 * PERIOD);

    waitPhase(137);
    applyStimulus(256, -100);
    idle(2 * PERIOD);

    applyStimulus(512, -100);
    applyStimulus(-512, -100);
    idle(2 * PERIOD);

    applyStimulus(-1024, -100);
    applyStimulus(0, -100);
    idle(2 * PERIOD);

    $display("[TB] handshake stress");
    waitPhase(200);
    applyStimulus(300, 300);
    bus.lft_cmd = 11'd50;
    bus.rht_cmd = 11'd50;
    bus.cmd_vld = 1'b1;
    repeat (5) tick(c);
    bus.cmd_vld = 1'b0;
    idle(2 * PERIOD);

    waitPhase(0);
    bus.lft_cmd = 11'h5A8;
    bus.rht_cmd = 11'd450;
    bus.cmd_vld = 1'b1;
    tick(c);
    bus.cmd_vld = 1'b0;
    idle(3 * PERIOD);

    $display("[TB] random commands");
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 1500));
      case ($urandom_range(0, 7))
        0:       l = -1024;
        1:       l = 0;
        2:       l = 1023;
        default: begin
          l = $urandom_range(0, 2047);
          if (l >= 1024) l = l - 2048;
        end
      endcase
      r = $urandom_range(0, 2047);
      if (r >= 1024) r = r - 2048;
      applyStimulus(l, r);
    end
    idle(2 * PERIOD);

    $display("[TB] mid-period reset");
    applyStimulus(700, -700);
    waitPhase(300);
    #1;
    doReset(3);
    idle(2 * PERIOD);
    applyStimulus(400, -800);
    idle(2 * PERIOD + 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/motor_drive.md
Name: motor_drive

Overview:
- Downstream consumer of the fixed-duty PWM stage's output format.
- Converts signed left/right drive commands from the steering controller into per-motor forward/reverse PWM pins for the H-bridge.
- Has its own free-running period counter, latches commands only at period boundaries, and inserts a dead interval on direction reversal so neither bridge leg is shoot-through-driven.

Parameters:
- CNT_W, 10, width of period counter; period = 2^CNT_W clocks.
- DEADTIME, 64, clocks both outputs of a motor are forced low after a direction reversal (1 ≤ DEADTIME < 2^CNT_W).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cmd_vld  in  1  new command pair present on lft_cmd/rht_cmd
- lft_cmd  in  CNT_W+1  signed left drive command (two's complement)
- rht_cmd  in  CNT_W+1  signed right drive command
- cmd_rdy  out  1  block can accept a command this cycle
- fwd_lft  out  1  left motor forward PWM
- rev_lft  out  1  left motor reverse PWM
- fwd_rht  out  1  right motor forward PWM
- rev_rht  out  1  right motor reverse PWM

Behaviour:
- Reset (async, immediate, also mid-period): cntr = all 1s; all PWM outputs 0; cmd_rdy = 1; pending buffer empty; active duty = 0; both motor FSMs in COAST; dead counters = 0.
- Period counter cntr: increments every clk and wraps at all 1s -> 0. The boundary cycle is cntr == all 1s.
- Handshake:
  - Capture occurs when cmd_vld & cmd_rdy: both commands go into the pending registers, and cmd_rdy drops on the next cycle.
  - On the boundary cycle with pending full, the pending commands become active, the buffer empties, and cmd_rdy = 1 on the next cycle.
  - A capture on the boundary cycle itself (buffer was empty) is applied at the next boundary, not the current one.
  - cmd_vld while cmd_rdy = 0 is ignored. The upstream must hold the command.
- Magnitude/sign:
  - duty = |cmd|, CNT_W bits.
  - The most negative value (-2^CNT_W) saturates to 2^CNT_W - 1.
  - sign > 0 means forward, sign < 0 means reverse, and cmd == 0 means coast.
- Per-motor FSM, evaluated at the apply (boundary) cycle:
  - COAST -> FWD or REV by new sign; stays in COAST on 0.
  - FWD -> FWD on positive; COAST on 0; DEAD on negative.
  - REV -> REV on negative; COAST on 0; DEAD on positive.
  - DEAD: dead counter loads DEADTIME at the apply cycle and decrements every clk.
    - Exits to the new direction state when it reaches 0.
    - A new apply while in DEAD reloads DEADTIME only if the new sign is opposite to the stored target direction. Otherwise only the target is updated.
    - A command of 0 in DEAD goes directly to COAST.
- PWM generation:
  - raw = (cntr < duty).
  - In FWD, raw drives fwd only; in REV, raw drives rev only. COAST and DEAD force both outputs to 0.
  - Duty 0 gives the output never high; duty 2^CNT_W - 1 gives high 1023 of every 1024 clocks.
- Latency:
  - Outputs are registered. Each output reflects cntr/state of the previous cycle.
  - After an apply at boundary cycle t, the first high output appears at t+2 when duty > 0 and there is no dead interval.
- Invariants:
  - fwd_x & rev_x is never 1.
  - On reversal, both outputs of that motor are 0 for at least DEADTIME consecutive clocks.
- Left and right motors are fully independent except for the shared cntr and the shared handshake.

Test Plan:
- Reset release, no commands -> all PWM outputs 0 for 3 full periods; cmd_rdy = 1.
- Command lft = +256, rht = -100, vld 1 clk -> cmd_rdy low until boundary.
  - fwd_lft high exactly 256 clk per 1024-clk period.
  - rev_rht high exactly 100 clk.
  - rev_lft and fwd_rht stay 0.
- lft = +512, then lft = -512 -> both left outputs 0 for at least 64 clk after the boundary, then rev_lft high 448 clk in that period and 512 in subsequent periods; fwd_lft & rev_lft never 1 simultaneously.
- lft = -1024 -> saturates; rev_lft high 1023 of 1024 clk. lft = 0 next -> both left outputs 0 from the following boundary.
- Handshake stress:
  - Second cmd_vld while cmd_rdy = 0 (values +50/+50) -> ignored; the first command (+300/+300) is applied.
  - Command captured exactly on the boundary cycle -> applied one period later.
- Assert rst_n low mid-period while outputs are high -> all outputs 0 within the same cycle (async); after release, behaviour matches fresh reset.
